mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter between the instruction cache and the data cache. It takes the icache's single-word reads and the dcache's two-word block fills/writebacks, grants one requester at a time, and drives the one RAM port. The dcache has priority, and an anti-starvation counter guarantees the icache forward progress. It is the stage directly downstream of both caches and directly upstream of the RAM model.

## Interface
- `STARVE_MAX`, default 4: number of consecutive dcache bursts allowed while an icache request waits; the next arbitration then goes to the icache.
- `BURST_LEN`, default 2: maximum dcache beats held under one grant.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `iREN` in 1: icache read request.
- `iaddr` in 32: icache word address.
- `iwait` out 1: icache stall; low only for the cycle in which `iload` is valid.
- `iload` out 32: icache read data.
- `dREN`, `dWEN` in 1 each: dcache read/write request. Both high together is a write.
- `daddr`, `dstore` in 32 each: dcache address and write data.
- `dwait` out 1: dcache stall; low for one cycle per completed beat.
- `dload` out 32: dcache read data.
- `ramREN`, `ramWEN` out 1 each: RAM strobes.
- `ramaddr`, `ramstore` out 32 each: RAM address and write data.
- `ramload` in 32: RAM read data.
- `ramstate` in 2: `ramstate_t`, one of FREE, BUSY, ACCESS, ERROR.
- `icount`, `dcount` out 32: completed icache words and completed dcache beats. Free-running; wrap at 2^32.
- `errcount` out 16: number of ERROR responses seen. Saturates at 0xFFFF.

## Operation
- States (`arb_state_t`): IDLE, IGRANT, DGRANT.
- IDLE, evaluated in priority order:
  - If `iREN` and `starve_cnt == STARVE_MAX`: go to IGRANT.
  - Else if `dREN|dWEN`: go to DGRANT, with `beat = 0`.
  - Else if `iREN`: go to IGRANT.
  - In IDLE all RAM strobes are 0, and `iwait = dwait = 1`.
- IGRANT:
  - Drive `ramREN = 1` and `ramaddr = iaddr`.
  - On ACCESS: `iwait = 0`, `iload = ramload`, increment `icount`, clear `starve_cnt`, go to IDLE.
  - If `iREN` drops before ACCESS: abort, strobes low, go to IDLE, no count.
- DGRANT:
  - Drive `ramWEN = dWEN`, `ramREN = dREN & ~dWEN`, `ramaddr = daddr`, `ramstore = dstore`.
  - On ACCESS: `dwait = 0`, `dload = ramload`, increment `dcount`, increment `beat`.
  - If `beat + 1 < BURST_LEN` and a request is still asserted the next cycle: stay in DGRANT.
  - Otherwise go to IDLE. On the exit, if `iREN` is high, `starve_cnt` increments (saturating at STARVE_MAX).
  - If the request drops before ACCESS: abort to IDLE.
- ERROR on ramstate, in either grant state:
  - The wait signal stays high and the strobes drop.
  - `errcount` increments and the FSM goes to IDLE. The requester re-requests naturally.
- FREE/BUSY in a grant state: hold all outputs and stay in the state.
- Outputs not selected by the current state:
  - `iload` and `dload` read 0 whenever their wait is high.
  - `ramstore` reads 0 unless `ramWEN = 1`.

## Timing
- Reset (`RST` high at an edge):
  - state IDLE; `beat`, `starve_cnt`, `icount`, `dcount`, `errcount` = 0.
  - `ramREN = ramWEN = 0`, `ramaddr = ramstore = 0`.
  - `iwait = dwait = 1`; `iload = dload = 0`.
  - Reset in the middle of a grant abandons the transaction with no count update.
- Latency:
  - A request arriving in IDLE at cycle N is driven to RAM from cycle N+1.
  - For a RAM that returns ACCESS on its first driven cycle, the first beat completes (wait low) in cycle N+1.
  - A two-beat dcache burst with a zero-latency RAM takes 3 cycles: arbitrate, beat 0, beat 1.
- Outputs:
  - RAM strobes, `ramaddr`, `ramstore`, `iwait`, `dwait`, `iload`, `dload` are combinational from state, inputs and `ramstate`.
  - Counters and state are registered.
- Simultaneous requests in IDLE go to the dcache, except when `starve_cnt == STARVE_MAX`.
- The icache is never granted in the middle of a dcache burst.
- When the dcache address changes between beats, the new `daddr` is used without re-arbitration.

## Structure
- In `cpu_types_pkg`: `arb_state_t` and the existing `ramstate_t`.
- Two sub-modules:
  - `arb_counters`: owns `icount`, `dcount` and the saturating `errcount`, driven by beat-complete and error pulses.
  - The FSM and muxing stay in `mem_arbiter`.

## Test plan
- `iREN = 1`, `iaddr = 0x40`, RAM ACCESS immediately, `ramload = 0xDEADBEEF` → `ramaddr = 0x40` the cycle after the request, `iwait` low for one cycle with `iload = 0xDEADBEEF`, `icount = 1`.
- dcache two-beat write at 0x100 then 0x104, RAM BUSY for 2 cycles per beat → `ramWEN` high across both beats, `dwait` pulses twice, `dcount = 2`, icache never granted in between.
- `iREN` and `dREN` asserted together, continuously, with `STARVE_MAX = 4` → exactly 4 dcache bursts, then 1 icache word, then the pattern repeats.
- ramstate ERROR during IGRANT → `iwait` stays high, `errcount = 1`, FSM returns to IDLE and re-grants the next cycle.
- `RST` asserted while in DGRANT with RAM BUSY → the next cycle shows all strobes 0, `dwait = 1`, all counters 0, state IDLE.
- `dREN` dropped before ACCESS → abort, `dcount` unchanged, pending `iREN` granted next.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
// Shared types for the memory subsystem.
//   ramstate_t  : status reported by the RAM model on its single port.
//   arb_state_t : grant state of the icache/dcache memory arbiter.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_counters.sv
// arb_counters
// Statistics counters for the memory arbiter.
//   CLK, RST  : clock, synchronous active-high reset
//   i_done    : one-cycle pulse per completed icache word
//   d_done    : one-cycle pulse per completed dcache beat
//   err       : one-cycle pulse per ERROR response from RAM
//   icount    : completed icache words (wraps)
//   dcount    : completed dcache beats (wraps)
//   errcount  : ERROR responses seen (saturates at 0xFFFF)
module arb_counters (
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_done,
    input  logic        d_done,
    input  logic        err,
    output logic [31:0] icount,
    output logic [31:0] dcount,
    output logic [15:0] errcount
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            icount   <= '0;
            dcount   <= '0;
            errcount <= '0;
        end else begin
            if (i_done) icount <= icount + 32'd1;
            if (d_done) dcount <= dcount + 32'd1;
            if (err && (errcount != 16'hFFFF)) errcount <= errcount + 16'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Single-port RAM arbiter between the icache (single-word reads) and the
// dcache (bursts of up to BURST_LEN beats). The dcache has priority; after
// STARVE_MAX consecutive dcache bursts with an icache request waiting, the
// next arbitration goes to the icache.
//
// Ports:
//   CLK, RST                  : clock, synchronous active-high reset
//   iREN, iaddr               : icache read request / word address
//   iwait, iload              : icache stall / read data
//   dREN, dWEN, daddr, dstore : dcache read/write request, address, data
//   dwait, dload              : dcache stall / read data
//   ramREN, ramWEN            : RAM strobes
//   ramaddr, ramstore         : RAM address / write data
//   ramload, ramstate         : RAM read data / status
//   icount, dcount, errcount  : statistics
//   state                     : current arbiter state (debug visibility)
//
// Handshake: a requester holds its request and address stable while its
// wait is high; wait low for exactly one cycle marks a completed word/beat,
// with the read data valid in that same cycle. Dropping a request before
// completion abandons it with no count.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int BURST_LEN  = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  ramstate_t   ramstate,
    output logic [31:0] icount,
    output logic [31:0] dcount,
    output logic [15:0] errcount,
    output arb_state_t  state
);

    localparam logic [31:0] STARVE_U = 32'(STARVE_MAX);
    localparam logic [31:0] BURST_U  = 32'(BURST_LEN);

    arb_state_t  state_q, state_d;
    logic [31:0] beat_q, beat_d;
    logic [31:0] starve_q, starve_d;
    logic        i_done, d_done, err;
    logic        d_exit;
    logic        dreq;

    assign dreq  = dREN | dWEN;
    assign state = state_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        starve_d = starve_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        i_done   = 1'b0;
        d_done   = 1'b0;
        err      = 1'b0;
        d_exit   = 1'b0;

        case (state_q)
            IDLE: begin
                if (iREN && (starve_q == STARVE_U)) begin
                    state_d = IGRANT;
                end else if (dreq) begin
                    state_d = DGRANT;
                    beat_d  = '0;
                end else if (iREN) begin
                    state_d = IGRANT;
                end
            end

            IGRANT: begin
                if (!iREN) begin
                    state_d = IDLE;
                end else if (ramstate == ERROR) begin
                    err     = 1'b1;
                    state_d = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ramstate == ACCESS) begin
                        iwait    = 1'b0;
                        iload    = ramload;
                        i_done   = 1'b1;
                        starve_d = '0;
                        state_d  = IDLE;
                    end
                end
            end

            DGRANT: begin
                // A burst counts toward icache starvation once at least one
                // beat of it has completed, however it ends.
                if (!dreq) begin
                    state_d = IDLE;
                    d_exit  = (beat_q != '0);
                end else if (ramstate == ERROR) begin
                    err     = 1'b1;
                    state_d = IDLE;
                    d_exit  = (beat_q != '0);
                end else begin
                    ramWEN  = dWEN;
                    ramREN  = dREN & ~dWEN;
                    ramaddr = daddr;
                    if (dWEN) ramstore = dstore;
                    if (ramstate == ACCESS) begin
                        dwait  = 1'b0;
                        dload  = ramload;
                        d_done = 1'b1;
                        beat_d = beat_q + 32'd1;
                        // Staying here is provisional: if the request drops
                        // next cycle, the !dreq branch closes the burst.
                        if (!((beat_q + 32'd1) < BURST_U)) begin
                            state_d = IDLE;
                            d_exit  = 1'b1;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        if (d_exit && iREN && (starve_q < STARVE_U))
            starve_d = starve_q + 32'd1;
    end

    arb_counters u_counters (
        .CLK      (CLK),
        .RST      (RST),
        .i_done   (i_done),
        .d_done   (d_done),
        .err      (err),
        .icount   (icount),
        .dcount   (dcount),
        .errcount (errcount)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter: reset state, icache read, dcache write
// burst with wait states, ERROR handling, reset mid-grant, dcache abort,
// and the dcache/icache starvation pattern.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    ramstate_t   ramstate;
    logic [31:0] icount;
    logic [31:0] dcount;
    logic [15:0] errcount;
    arb_state_t  st;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] i_seq;
    logic [31:0] d_seq;

    mem_arbiter #(.STARVE_MAX(4), .BURST_LEN(2)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .icount   (icount),
        .dcount   (dcount),
        .errcount (errcount),
        .state    (st)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one cycle; inputs are then changed 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        iREN     = 1'b0;
        iaddr    = '0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        ramload  = '0;
        ramstate = FREE;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        clear_inputs();
        tick();
        tick();
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        clear_inputs();

        // ---------------- reset state ----------------
        do_reset();
        #1;
        chk("rst_state", 32'(st), 32'(IDLE));
        chk1("rst_ramREN", ramREN, 1'b0);
        chk1("rst_ramWEN", ramWEN, 1'b0);
        chk("rst_ramaddr", ramaddr, 32'h0);
        chk("rst_ramstore", ramstore, 32'h0);
        chk1("rst_iwait", iwait, 1'b1);
        chk1("rst_dwait", dwait, 1'b1);
        chk("rst_iload", iload, 32'h0);
        chk("rst_dload", dload, 32'h0);
        chk("rst_icount", icount, 32'h0);
        chk("rst_dcount", dcount, 32'h0);
        chk("rst_errcount", 32'(errcount), 32'h0);

        // ---------------- icache single read ----------------
        iREN = 1'b1; iaddr = 32'h40; ramstate = ACCESS; ramload = 32'hDEADBEEF;
        #1;
        chk1("i_arb_ramREN", ramREN, 1'b0);
        chk1("i_arb_iwait", iwait, 1'b1);
        chk("i_arb_iload", iload, 32'h0);
        tick(); #1;
        chk("i_gnt_state", 32'(st), 32'(IGRANT));
        chk1("i_gnt_ramREN", ramREN, 1'b1);
        chk("i_gnt_ramaddr", ramaddr, 32'h40);
        chk1("i_gnt_iwait", iwait, 1'b0);
        chk("i_gnt_iload", iload, 32'hDEADBEEF);
        chk("i_gnt_icount_pre", icount, 32'h0);
        tick();
        iREN = 1'b0;
        #1;
        chk("i_done_state", 32'(st), 32'(IDLE));
        chk1("i_done_iwait", iwait, 1'b1);
        chk("i_done_iload", iload, 32'h0);
        chk("i_done_icount", icount, 32'h1);

        // ------- dcache two-beat write, 2 BUSY cycles per beat, iREN pending -------
        do_reset();
        dWEN = 1'b1; daddr = 32'h100; dstore = 32'hA5A50001; ramstate = BUSY;
        iREN = 1'b1; iaddr = 32'h80;
        #1;
        chk1("dw_arb_dwait", dwait, 1'b1);
        chk1("dw_arb_ramWEN", ramWEN, 1'b0);
        tick(); #1;
        chk("dw_b0_state", 32'(st), 32'(DGRANT));
        chk1("dw_b0_ramWEN", ramWEN, 1'b1);
        chk1("dw_b0_ramREN", ramREN, 1'b0);
        chk("dw_b0_ramaddr", ramaddr, 32'h100);
        chk("dw_b0_ramstore", ramstore, 32'hA5A50001);
        chk1("dw_b0_dwait_busy1", dwait, 1'b1);
        tick(); #1;
        chk1("dw_b0_ramWEN_busy2", ramWEN, 1'b1);
        chk1("dw_b0_dwait_busy2", dwait, 1'b1);
        tick();
        ramstate = ACCESS;
        #1;
        chk1("dw_b0_dwait_acc", dwait, 1'b0);
        chk1("dw_b0_iwait_acc", iwait, 1'b1);
        tick();
        daddr = 32'h104; dstore = 32'hA5A50002; ramstate = BUSY;
        #1;
        chk("dw_b1_state", 32'(st), 32'(DGRANT));
        chk("dw_b1_ramaddr", ramaddr, 32'h104);
        chk1("dw_b1_ramWEN", ramWEN, 1'b1);
        chk1("dw_b1_dwait_busy", dwait, 1'b1);
        chk1("dw_b1_iwait", iwait, 1'b1);
        chk("dw_b1_dcount", dcount, 32'h1);
        tick(); #1;
        chk1("dw_b1_ramWEN_busy2", ramWEN, 1'b1);
        tick();
        ramstate = ACCESS;
        #1;
        chk1("dw_b1_dwait_acc", dwait, 1'b0);
        chk("dw_b1_ramstore", ramstore, 32'hA5A50002);
        tick();
        dWEN = 1'b0;
        #1;
        chk("dw_end_state", 32'(st), 32'(IDLE));
        chk("dw_end_dcount", dcount, 32'h2);
        chk("dw_end_icount", icount, 32'h0);
        chk1("dw_end_ramWEN", ramWEN, 1'b0);
        chk("dw_end_ramstore", ramstore, 32'h0);
        tick(); #1;
        chk("dw_i_state", 32'(st), 32'(IGRANT));
        chk("dw_i_ramaddr", ramaddr, 32'h80);
        chk1("dw_i_iwait", iwait, 1'b0);

        // ---------------- ERROR during IGRANT ----------------
        do_reset();
        iREN = 1'b1; iaddr = 32'h200; ramstate = ERROR;
        #1;
        tick(); #1;
        chk("err_state", 32'(st), 32'(IGRANT));
        chk1("err_iwait", iwait, 1'b1);
        chk1("err_ramREN", ramREN, 1'b0);
        tick();
        ramstate = ACCESS; ramload = 32'h00001234;
        #1;
        chk("err_idle_state", 32'(st), 32'(IDLE));
        chk("err_errcount", 32'(errcount), 32'h1);
        chk("err_icount", icount, 32'h0);
        tick(); #1;
        chk("err_regrant_state", 32'(st), 32'(IGRANT));
        chk1("err_regrant_iwait", iwait, 1'b0);
        chk("err_regrant_iload", iload, 32'h00001234);
        tick();
        iREN = 1'b0;
        #1;
        chk("err_end_icount", icount, 32'h1);

        // ---------------- reset in DGRANT with RAM BUSY ----------------
        dREN = 1'b1; daddr = 32'h300; ramstate = BUSY;
        #1;
        tick(); #1;
        chk("rmid_state_pre", 32'(st), 32'(DGRANT));
        chk1("rmid_ramREN_pre", ramREN, 1'b1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        chk("rmid_state", 32'(st), 32'(IDLE));
        chk1("rmid_ramREN", ramREN, 1'b0);
        chk1("rmid_ramWEN", ramWEN, 1'b0);
        chk1("rmid_dwait", dwait, 1'b1);
        chk("rmid_icount", icount, 32'h0);
        chk("rmid_dcount", dcount, 32'h0);
        chk("rmid_errcount", 32'(errcount), 32'h0);

        // ---------------- dREN dropped before ACCESS ----------------
        iREN = 1'b1; iaddr = 32'h500; dstore = 32'h0BAD0BAD;
        #1;
        tick(); #1;
        chk("ab_state", 32'(st), 32'(DGRANT));
        chk1("ab_ramREN", ramREN, 1'b1);
        chk("ab_ramstore_read", ramstore, 32'h0);
        tick();
        dREN = 1'b0;
        #1;
        chk1("ab_drop_ramREN", ramREN, 1'b0);
        chk1("ab_drop_dwait", dwait, 1'b1);
        tick(); #1;
        chk("ab_idle_state", 32'(st), 32'(IDLE));
        chk("ab_dcount", dcount, 32'h0);
        tick(); #1;
        chk("ab_i_state", 32'(st), 32'(IGRANT));
        chk("ab_i_ramaddr", ramaddr, 32'h500);

        // ---------------- starvation pattern ----------------
        // Period of 14 cycles: 4 bursts of (IDLE, beat0, beat1), then IDLE, IGRANT.
        do_reset();
        iREN = 1'b1; iaddr = 32'h600; dREN = 1'b1; daddr = 32'h700; ramstate = ACCESS;
        i_seq = '0;
        d_seq = '0;
        for (int c = 0; c < 28; c++) begin
            #1;
            i_seq[c] = ~iwait;
            d_seq[c] = ~dwait;
            tick();
        end
        chk("starve_i_seq", i_seq, 32'h08002000);
        chk("starve_d_seq", d_seq, 32'h036D8DB6);
        chk("starve_icount", icount, 32'd2);
        chk("starve_dcount", dcount, 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
